// File: rtl/fixed4_pkg.sv
// Shared types and widths for the fixed4 PE column controller.
package fixed4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int ACT_W = 8;
  localparam int WGT_W = 4;

  function automatic int psum_w(input int col_width);
    return 2 * col_width;
  endfunction

endpackage

// File: rtl/fixed4_skew_line.sv
// DEPTH-cycle activation delay for one PE row; DEPTH=0 degenerates to a wire.
module fixed4_skew_line
  import fixed4_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [ACT_W-1:0] din,
  output logic [ACT_W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, clr_n};
      assign dout      = din;
    end else begin : g_sr
      logic [DEPTH-1:0][ACT_W-1:0] sr_q, sr_d;

      always_comb begin
        sr_d[0] = din;
        for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
      end

      always_ff @(posedge clk) begin
        if (!clr_n) sr_q <= '0;
        else        sr_q <= sr_d;
      end

      assign dout = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fixed4_col_ctrl.sv
// Sequencer for a weight-stationary column of ROWS fixed4 PEs: weight load,
// skewed activation streaming and result tagging from the last row.
module fixed4_col_ctrl
  import fixed4_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COL_WIDTH = 11,
  parameter int LEN_W     = 8,
  localparam int PSUM_W   = psum_w(COL_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    cfg_s_in,
  input  logic                    cfg_s_weight,
  input  logic [LEN_W-1:0]        cfg_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    w_valid,
  input  logic [WGT_W-1:0]        w_data,
  output logic                    w_ready,
  input  logic                    act_valid,
  input  logic [ROWS*ACT_W-1:0]   act_data,
  output logic                    act_ready,
  output logic                    res_valid,
  output logic [PSUM_W-1:0]       res_data,
  output logic                    res_last,
  output logic [ROWS*ACT_W-1:0]   pe_in,
  output logic [ROWS*WGT_W-1:0]   pe_weight,
  output logic                    pe_s_in,
  output logic                    pe_s_weight,
  output logic [PSUM_W-1:0]       pe_psum_in0,
  input  logic [PSUM_W-1:0]       pe_psum_last
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              w_cnt_q, w_cnt_d;
  logic [LEN_W-1:0]              act_cnt_q, act_cnt_d;
  logic [LEN_W-1:0]              len_q, len_d;
  logic                          s_in_q, s_in_d, s_w_q, s_w_d;
  logic [ROWS-1:0][WGT_W-1:0]    weight_q, weight_d;
  logic [ROWS-1:0]               vld_pipe_q, vld_pipe_d;
  logic [ROWS-1:0]               last_pipe_q, last_pipe_d;

  logic                          w_fire, act_fire, act_is_last, skew_clr_n;
  logic [ROWS-1:0][ACT_W-1:0]    skew_in, skew_out;

  assign w_ready     = (state_q == LOAD_W);
  assign act_ready   = (state_q == STREAM);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign w_fire      = w_valid & w_ready;
  assign act_fire    = act_valid & act_ready;
  assign act_is_last = (act_cnt_q == len_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    w_cnt_d     = w_cnt_q;
    act_cnt_d   = act_cnt_q;
    len_d       = len_q;
    s_in_d      = s_in_q;
    s_w_d       = s_w_q;
    weight_d    = weight_q;

    // Tags ride alongside the data so the result lands exactly ROWS cycles later.
    vld_pipe_d[0]  = act_fire;
    last_pipe_d[0] = act_fire & act_is_last;
    for (int r = 1; r < ROWS; r++) begin
      vld_pipe_d[r]  = vld_pipe_q[r-1];
      last_pipe_d[r] = last_pipe_q[r-1];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            s_in_d    = cfg_s_in;
            s_w_d     = cfg_s_weight;
            len_d     = cfg_len;
            w_cnt_d   = '0;
            act_cnt_d = '0;
            state_d   = LOAD_W;
          end else begin
            state_d   = DONE;
          end
        end
      end
      LOAD_W: begin
        if (w_fire) begin
          for (int r = 0; r < ROWS; r++)
            if (w_cnt_q == CNT_W'(r)) weight_d[r] = w_data;
          if (w_cnt_q == CNT_W'(ROWS - 1)) begin
            w_cnt_d = '0;
            state_d = STREAM;
          end else begin
            w_cnt_d = w_cnt_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (act_fire) begin
          act_cnt_d = act_cnt_q + 1'b1;
          if (act_is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the cycle the final result is presented.
        if (vld_pipe_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_cnt_q     <= '0;
      act_cnt_q   <= '0;
      len_q       <= '0;
      s_in_q      <= 1'b0;
      s_w_q       <= 1'b0;
      weight_q    <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      act_cnt_q   <= act_cnt_d;
      len_q       <= len_d;
      s_in_q      <= s_in_d;
      s_w_q       <= s_w_d;
      weight_q    <= weight_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

  assign skew_clr_n = rst_n & ((state_q == STREAM) | (state_q == DRAIN));

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign skew_in[r] = act_fire ? act_data[r*ACT_W +: ACT_W] : '0;

      fixed4_skew_line #(.DEPTH(r)) u_skew (
        .clk   (clk),
        .clr_n (skew_clr_n),
        .din   (skew_in[r]),
        .dout  (skew_out[r])
      );

      assign pe_in[r*ACT_W +: ACT_W] = skew_out[r];
    end
  endgenerate

  assign pe_weight   = weight_q;
  assign pe_s_in     = s_in_q;
  assign pe_s_weight = s_w_q;
  assign pe_psum_in0 = '0;
  assign res_valid   = vld_pipe_q[ROWS-1];
  assign res_last    = last_pipe_q[ROWS-1];
  assign res_data    = res_valid ? pe_psum_last : '0;

endmodule

// File: tb/tb_fixed4_col_ctrl.sv
// Directed bench for fixed4_col_ctrl driving a behavioural 4-row PE column,
// with a cycle-stamped result scoreboard.
module tb_fixed4_col_ctrl;
  import fixed4_pkg::*;

  localparam int ROWS = 4;
  localparam int CW   = 11;
  localparam int LW   = 8;
  localparam int PW   = 2 * CW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0, cfg_s_in = 1'b0, cfg_s_weight = 1'b0;
  logic [LW-1:0]        cfg_len = '0;
  logic                 busy, done, w_ready, act_ready, res_valid, res_last;
  logic                 w_valid = 1'b0, act_valid = 1'b0;
  logic [3:0]           w_data = '0;
  logic [ROWS*8-1:0]    act_data = '0;
  logic [PW-1:0]        res_data, pe_psum_in0, pe_psum_last;
  logic [ROWS*8-1:0]    pe_in;
  logic [ROWS*4-1:0]    pe_weight;
  logic                 pe_s_in, pe_s_weight;

  always #5 clk = ~clk;

  fixed4_col_ctrl #(.ROWS(ROWS), .COL_WIDTH(CW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_s_in(cfg_s_in),
    .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len), .busy(busy), .done(done),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
    .pe_in(pe_in), .pe_weight(pe_weight), .pe_s_in(pe_s_in),
    .pe_s_weight(pe_s_weight), .pe_psum_in0(pe_psum_in0),
    .pe_psum_last(pe_psum_last)
  );

  function automatic logic [PW-1:0] mac(logic [7:0] a, logic [3:0] w, logic sa, logic sw);
    int ai, wi;
    ai = sa ? int'($signed(a)) : int'(a);
    wi = sw ? int'($signed(w)) : int'(w);
    return PW'(ai * wi);
  endfunction

  function automatic logic [PW-1:0] dot(logic [31:0] v, logic [15:0] w, logic si, logic sw);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < ROWS; i++) s = s + mac(v[8*i +: 8], w[4*i +: 4], si, sw);
    return s;
  endfunction

  // Behavioural PE column: each row registers psum_in + act*weight.
  logic [PW-1:0] fwd [ROWS];
  for (genvar r = 0; r < ROWS; r++) begin : g_pe
    logic [PW-1:0] pin, q;
    if (r == 0) begin : g_first
      assign pin = pe_psum_in0;
    end else begin : g_chain
      assign pin = fwd[r-1];
    end
    always_ff @(posedge clk) begin
      if (!rst_n) q <= '0;
      else        q <= pin + mac(pe_in[8*r +: 8], pe_weight[4*r +: 4], pe_s_in, pe_s_weight);
    end
    assign fwd[r] = q;
  end
  assign pe_psum_last = fwd[ROWS-1];

  typedef struct {
    logic [PW-1:0] d;
    logic          last;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int done_cnt = 0, done_cyc = -1, last_res_cyc = -1;
  bit wr_seen = 1'b0, ar_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result/done monitor, sampled on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (w_ready) wr_seen = 1'b1;
    if (act_ready) ar_seen = 1'b1;
    if (res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("res_data", res_data, e.d);
        chk("res_last", res_last, e.last);
        chk("res_cycle", cyc, e.cyc);
        if (res_last) last_res_cyc = cyc;
      end
    end else begin
      if (res_last) chk("res_last_without_valid", 64'd1, 64'd0);
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        chk("res_missing", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic si, input logic sw, input int len, input bit hold);
    start = 1'b1; cfg_s_in = si; cfg_s_weight = sw; cfg_len = LW'(len);
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic load(input logic [15:0] w, input int stall);
    int n;
    for (int i = 0; i < ROWS; i++) begin
      w_valid = 1'b0;
      repeat (stall) tick();
      w_valid = 1'b1; w_data = w[4*i +: 4];
      n = 0;
      while (!w_ready && n < 20) begin tick(); n++; end
      if (!w_ready) chk("w_ready_timeout", 64'd0, 64'd1);
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input logic [PW-1:0] e, input logic last);
    int n;
    act_valid = 1'b1; act_data = v;
    n = 0;
    while (!act_ready && n < 20) begin tick(); n++; end
    if (!act_ready) chk("act_ready_timeout", 64'd0, 64'd1);
    else sb.push_back('{e, last, cyc + ROWS});
    tick();
    act_valid = 1'b0; act_data = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("job_ends", busy, 1'b0);
  endtask

  initial begin
    int d0, k;
    logic [31:0] v1, v2;
    logic [15:0] w;

    rst_n = 1'b0;
    tick(); tick();
    chk("reset_ctrl", {busy, done, w_ready, act_ready, res_valid, res_last, pe_s_in, pe_s_weight}, '0);
    chk("reset_res_data", res_data, '0);
    chk("reset_pe_in", pe_in, '0);
    chk("reset_pe_weight", pe_weight, '0);
    chk("reset_psum_in0", pe_psum_in0, '0);
    rst_n = 1'b1;
    tick();

    // 1: unsigned, K=2
    d0 = done_cnt;
    do_start(1'b0, 1'b0, 2, 1'b0);
    chk("t1_busy", busy, 1'b1);
    chk("t1_w_ready", w_ready, 1'b1);
    load(16'h4321, 0);
    chk("t1_weights", pe_weight, 16'h4321);
    chk("t1_act_ready", act_ready, 1'b1);
    send(32'h01010101, PW'(10), 1'b0);
    send(32'h01000002, PW'(6), 1'b1);
    chk("t1_act_ready_drain", act_ready, 1'b0);
    wait_idle();
    chk("t1_done_cnt", done_cnt, d0 + 1);
    chk("t1_done_after_last", done_cyc, last_res_cyc + 1);
    chk("t1_sb_empty", sb.size(), 0);

    // 2: signed both, -1 weights, 0x80 activations
    d0 = done_cnt;
    do_start(1'b1, 1'b1, 1, 1'b0);
    load(16'hFFFF, 0);
    chk("t2_s_in", pe_s_in, 1'b1);
    chk("t2_s_w", pe_s_weight, 1'b1);
    send(32'h80808080, PW'(512), 1'b1);
    wait_idle();
    chk("t2_done_cnt", done_cnt, d0 + 1);

    // 3: bubble between two vectors
    d0 = done_cnt;
    w = 16'hF3E1;
    v1 = 32'h05FF1007;
    v2 = 32'h20010280;
    do_start(1'b0, 1'b1, 2, 1'b0);
    load(w, 0);
    send(v1, dot(v1, w, 1'b0, 1'b1), 1'b0);
    tick();
    send(v2, dot(v2, w, 1'b0, 1'b1), 1'b1);
    wait_idle();
    chk("t3_done_cnt", done_cnt, d0 + 1);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: zero-length job
    d0 = done_cnt;
    wr_seen = 1'b0; ar_seen = 1'b0;
    k = cyc;
    do_start(1'b0, 1'b0, 0, 1'b0);
    chk("t4_done", done, 1'b1);
    tick();
    chk("t4_idle", busy, 1'b0);
    chk("t4_done_cyc", done_cyc, k + 1);
    chk("t4_done_cnt", done_cnt, d0 + 1);
    chk("t4_no_w_ready", wr_seen, 1'b0);
    chk("t4_no_act_ready", ar_seen, 1'b0);

    // 5: reset mid-stream after 1 of 3 vectors
    d0 = done_cnt;
    do_start(1'b0, 1'b0, 3, 1'b0);
    load(16'h1111, 0);
    send(32'h01010101, PW'(4), 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_reset_ctrl", {busy, done, w_ready, act_ready, res_valid, res_last, pe_s_in, pe_s_weight}, '0);
    chk("t5_reset_res_data", res_data, '0);
    chk("t5_reset_pe_in", pe_in, '0);
    chk("t5_reset_pe_weight", pe_weight, '0);
    sb.delete();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t5_no_done", done_cnt, d0);
    chk("t5_idle", busy, 1'b0);
    do_start(1'b0, 1'b0, 1, 1'b0);
    load(16'h2071, 0);
    send(32'h03090205, PW'(25), 1'b1);
    wait_idle();
    chk("t5_new_job_done", done_cnt, d0 + 1);

    // 6: start held during job, stalled weight beats
    d0 = done_cnt;
    w = 16'h6253;
    v1 = 32'h01020304;
    v2 = 32'hFF000001;
    do_start(1'b0, 1'b0, 2, 1'b1);
    cfg_s_in = 1'b1; cfg_s_weight = 1'b1; cfg_len = LW'(5);
    load(w, 2);
    chk("t6_weights", pe_weight, w);
    chk("t6_s_in", pe_s_in, 1'b0);
    chk("t6_s_w", pe_s_weight, 1'b0);
    send(v1, dot(v1, w, 1'b0, 1'b0), 1'b0);
    send(v2, dot(v2, w, 1'b0, 1'b0), 1'b1);
    chk("t6_len_kept", act_ready, 1'b0);
    start = 1'b0;
    wait_idle();
    chk("t6_done_cnt", done_cnt, d0 + 1);
    chk("t6_s_in_hold", pe_s_in, 1'b0);
    chk("t6_weights_hold", pe_weight, w);
    chk("t6_sb_empty", sb.size(), 0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
